pc_unit: RTL and testbench

- Parametrised program-counter unit; successor to the single-register PC.
- Holds the fetch PC and selects next PC: sequential, branch or jump.
- Adds a halt/resume state machine, a saturating advance counter and a redirect flag.
- Sits between the control unit / branch comparator and instruction memory address in the CPU datapath.

---
 rtl/pc_unit_if.sv | 38 +++
 rtl/pc_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit_if
//  Purpose  : Bundle of select/control inputs and PC status outputs shared
//             between the control unit (master) and the PC unit (slave).
//  Signals  : en, branch, br_offset, jump, jmp_target, halt_req, go  (m -> s)
//             pc, pc_plus, halted, redirect, adv_cnt, trap            (s -> m)
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_unit_if #(
   parameter int WIDTH     = 32,
   parameter int CNT_WIDTH = 32
);
   logic                 en;
   logic                 branch;
   logic [WIDTH-1:0]     br_offset;
   logic                 jump;
   logic [WIDTH-1:0]     jmp_target;
   logic                 halt_req;
   logic                 go;
   logic [WIDTH-1:0]     pc;
   logic [WIDTH-1:0]     pc_plus;
   logic                 halted;
   logic                 redirect;
   logic [CNT_WIDTH-1:0] adv_cnt;
   logic                 trap;

   modport master (
      output en, branch, br_offset, jump, jmp_target, halt_req, go,
      input  pc, pc_plus, halted, redirect, adv_cnt, trap
   );

   modport slave (
      input  en, branch, br_offset, jump, jmp_target, halt_req, go,
      output pc, pc_plus, halted, redirect, adv_cnt, trap
   );
endinterface
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Fetch program counter with sequential / branch / jump next-PC
//             selection, RUN/HALT state machine, saturating advance counter
//             and redirect flag.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-low reset (0 = reset)
//             bus  - pc_unit_if.slave (controls in, pc/status out)
//  Options  : PC_ALIGN_CHK_EN - when defined, a misaligned next PC is
//             replaced by TRAP_VEC and trap pulses for one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          INC       = 4,
   parameter int          CNT_WIDTH = 32,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
   input  wire logic  clk,
   input  wire logic  rst,
   pc_unit_if.slave   bus
);

   localparam logic [WIDTH-1:0]     c_RESET_PC = WIDTH'(RESET_VEC);
   localparam logic [WIDTH-1:0]     c_INC      = WIDTH'(INC);
   localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = {CNT_WIDTH{1'b1}};

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [WIDTH-1:0]     r_pc;
   logic [WIDTH-1:0]     w_pc_nxt;
   logic [WIDTH-1:0]     w_pc_plus;
   logic [WIDTH-1:0]     w_target;
   logic                 r_redirect;
   logic                 w_redirect_nxt;
   logic                 w_advance;
   logic [CNT_WIDTH-1:0] r_adv_cnt;

`ifdef PC_ALIGN_CHK_EN
   localparam logic [WIDTH-1:0] c_TRAP_PC = WIDTH'(TRAP_VEC);
   logic                 r_trap;
   logic                 w_trap_nxt;
`else
   // Trap target has no consumer when the alignment check is compiled out.
   logic                 w_unused_trap_vec;
   assign w_unused_trap_vec = ^TRAP_VEC;
`endif

   // Sequential successor, wraps modulo 2^WIDTH.
   assign w_pc_plus = r_pc + c_INC;

   // ---------------------------------------------------------------------
   // Next-state / next-PC selection
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = r_redirect;
      w_advance      = 1'b0;
      w_target       = w_pc_plus;
`ifdef PC_ALIGN_CHK_EN
      w_trap_nxt     = 1'b0;
`endif
      case (r_state)
         ST_RUN: begin
            if (bus.en) begin
               if (bus.halt_req) begin
                  // PC parks on the halting instruction; no advance counted.
                  w_state_nxt    = ST_HALT;
                  w_redirect_nxt = 1'b0;
               end else begin
                  w_advance = 1'b1;
                  if (bus.jump) begin
                     w_target       = bus.jmp_target;
                     w_redirect_nxt = 1'b1;
                  end else if (bus.branch) begin
                     w_target       = w_pc_plus + bus.br_offset;
                     w_redirect_nxt = 1'b1;
                  end else begin
                     w_redirect_nxt = 1'b0;
                  end
                  w_pc_nxt = w_target;
`ifdef PC_ALIGN_CHK_EN
                  if (w_target[1:0] != 2'b00) begin
                     w_pc_nxt       = c_TRAP_PC;
                     w_trap_nxt     = 1'b1;
                     w_redirect_nxt = 1'b1;
                  end
`endif
               end
            end
         end
         ST_HALT: begin
            // Only go matters here; en and all select inputs are ignored.
            if (bus.go) begin
               w_state_nxt = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= c_RESET_PC;
         r_redirect <= 1'b0;
         r_adv_cnt  <= '0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_redirect <= w_redirect_nxt;
         if (w_advance && (r_adv_cnt != c_CNT_MAX)) begin
            r_adv_cnt <= r_adv_cnt + c_CNT_ONE;
         end
      end
   end

`ifdef PC_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_trap <= 1'b0;
      end else begin
         r_trap <= w_trap_nxt;
      end
   end
   assign bus.trap = r_trap;
`else
   assign bus.trap = 1'b0;
`endif

   assign bus.pc       = r_pc;
   assign bus.pc_plus  = w_pc_plus;
   assign bus.halted   = (r_state == ST_HALT);
   assign bus.redirect = r_redirect;
   assign bus.adv_cnt  = r_adv_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Directed self-checking bench for pc_unit. A 32-bit instance
//             covers reset, sequencing, stall, jump, branch, halt priority,
//             async reset and the alignment trap; an 8-bit / 2-bit-counter
//             instance covers PC wrap and counter saturation.
//  Options  : PC_ALIGN_CHK_EN selects the expected trap behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pc_unit_if #(.WIDTH(32), .CNT_WIDTH(32)) m_if ();
   pc_unit_if #(.WIDTH(8),  .CNT_WIDTH(2))  s_if ();

   pc_unit #(
      .WIDTH(32), .RESET_VEC(32'h0000_0000), .INC(4),
      .CNT_WIDTH(32), .TRAP_VEC(32'h0000_0080)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if.slave)
   );

   pc_unit #(
      .WIDTH(8), .RESET_VEC(32'h0000_0000), .INC(4),
      .CNT_WIDTH(2), .TRAP_VEC(32'h0000_0080)
   ) u_dut_small (
      .clk (clk),
      .rst (rst),
      .bus (s_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m_if.en = 1'b0; m_if.branch = 1'b0; m_if.br_offset = '0;
      m_if.jump = 1'b0; m_if.jmp_target = '0; m_if.halt_req = 1'b0; m_if.go = 1'b0;
      s_if.en = 1'b0; s_if.branch = 1'b0; s_if.br_offset = '0;
      s_if.jump = 1'b0; s_if.jmp_target = '0; s_if.halt_req = 1'b0; s_if.go = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #3;
      n_checks++; if (m_if.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%0h exp=%0h", m_if.pc, 32'h0); end
      n_checks++; if (m_if.pc_plus !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus got=%0h exp=%0h", m_if.pc_plus, 32'h4); end
      n_checks++; if (m_if.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%0b exp=0", m_if.halted); end
      n_checks++; if (m_if.redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%0b exp=0", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_adv_cnt got=%0h exp=0", m_if.adv_cnt); end
      n_checks++; if (m_if.trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap got=%0b exp=0", m_if.trap); end
      #7;
      rst = 1'b1;
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      m_if.en = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         exp_pc = 32'(i * 4);
         n_checks++; if (m_if.pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc step=%0d got=%0h exp=%0h", i, m_if.pc, exp_pc); end
         n_checks++; if (m_if.redirect !== 1'b0) begin n_fail++; $display("FAIL seq_redirect step=%0d got=%0b exp=0", i, m_if.redirect); end
      end
      n_checks++; if (m_if.adv_cnt !== 32'd4) begin n_fail++; $display("FAIL seq_adv_cnt got=%0d exp=4", m_if.adv_cnt); end
      m_if.en = 1'b0;
   endtask

   task automatic test_stall_jump_branch();
      apply_reset();
      m_if.en = 1'b1;
      tick();
      tick();
      m_if.en = 1'b0;
      m_if.jump = 1'b1; m_if.jmp_target = 32'h0000_0300;  // ignored while stalled
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (m_if.pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc cyc=%0d got=%0h exp=8", i, m_if.pc); end
         n_checks++; if (m_if.adv_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_adv_cnt cyc=%0d got=%0d exp=2", i, m_if.adv_cnt); end
      end
      m_if.en = 1'b1; m_if.jmp_target = 32'h0000_0100;
      tick();
      n_checks++; if (m_if.pc !== 32'h100) begin n_fail++; $display("FAIL jump_pc got=%0h exp=100", m_if.pc); end
      n_checks++; if (m_if.redirect !== 1'b1) begin n_fail++; $display("FAIL jump_redirect got=%0b exp=1", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'd3) begin n_fail++; $display("FAIL jump_adv_cnt got=%0d exp=3", m_if.adv_cnt); end
      m_if.jump = 1'b0; m_if.branch = 1'b1; m_if.br_offset = 32'hFFFF_FFF8;
      #1;
      n_checks++; if (m_if.pc_plus !== 32'h104) begin n_fail++; $display("FAIL pc_plus_comb got=%0h exp=104", m_if.pc_plus); end
      tick();
      n_checks++; if (m_if.pc !== 32'hFC) begin n_fail++; $display("FAIL branch_pc got=%0h exp=fc", m_if.pc); end
      n_checks++; if (m_if.redirect !== 1'b1) begin n_fail++; $display("FAIL branch_redirect got=%0b exp=1", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'd4) begin n_fail++; $display("FAIL branch_adv_cnt got=%0d exp=4", m_if.adv_cnt); end
      m_if.branch = 1'b0;
      tick();
      n_checks++; if (m_if.pc !== 32'h100) begin n_fail++; $display("FAIL seq_after_branch_pc got=%0h exp=100", m_if.pc); end
      n_checks++; if (m_if.redirect !== 1'b0) begin n_fail++; $display("FAIL seq_after_branch_redirect got=%0b exp=0", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'd5) begin n_fail++; $display("FAIL seq_after_branch_adv_cnt got=%0d exp=5", m_if.adv_cnt); end
   endtask

   task automatic test_priority();
      m_if.en = 1'b1; m_if.jump = 1'b1; m_if.jmp_target = 32'h20;
      tick();
      n_checks++; if (m_if.pc !== 32'h20) begin n_fail++; $display("FAIL prio_setup_pc got=%0h exp=20", m_if.pc); end
      m_if.halt_req = 1'b1; m_if.jump = 1'b1; m_if.jmp_target = 32'h200;
      m_if.branch = 1'b1; m_if.br_offset = 32'h40;
      tick();
      n_checks++; if (m_if.halted !== 1'b1) begin n_fail++; $display("FAIL prio_halted got=%0b exp=1", m_if.halted); end
      n_checks++; if (m_if.pc !== 32'h20) begin n_fail++; $display("FAIL prio_pc got=%0h exp=20", m_if.pc); end
      n_checks++; if (m_if.redirect !== 1'b0) begin n_fail++; $display("FAIL prio_redirect got=%0b exp=0", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'd6) begin n_fail++; $display("FAIL prio_adv_cnt got=%0d exp=6", m_if.adv_cnt); end
      m_if.halt_req = 1'b0; m_if.branch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (m_if.pc !== 32'h20) begin n_fail++; $display("FAIL halt_hold_pc cyc=%0d got=%0h exp=20", i, m_if.pc); end
         n_checks++; if (m_if.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold_halted cyc=%0d got=%0b exp=1", i, m_if.halted); end
      end
      m_if.jump = 1'b0; m_if.go = 1'b1;
      tick();
      n_checks++; if (m_if.halted !== 1'b0) begin n_fail++; $display("FAIL go_halted got=%0b exp=0", m_if.halted); end
      n_checks++; if (m_if.pc !== 32'h20) begin n_fail++; $display("FAIL go_pc got=%0h exp=20", m_if.pc); end
      n_checks++; if (m_if.adv_cnt !== 32'd6) begin n_fail++; $display("FAIL go_adv_cnt got=%0d exp=6", m_if.adv_cnt); end
      m_if.go = 1'b0;
      tick();
      n_checks++; if (m_if.pc !== 32'h24) begin n_fail++; $display("FAIL resume_pc got=%0h exp=24", m_if.pc); end
      n_checks++; if (m_if.adv_cnt !== 32'd7) begin n_fail++; $display("FAIL resume_adv_cnt got=%0d exp=7", m_if.adv_cnt); end
      m_if.en = 1'b0; m_if.go = 1'b1;
      tick();
      n_checks++; if (m_if.halted !== 1'b0) begin n_fail++; $display("FAIL go_in_run_halted got=%0b exp=0", m_if.halted); end
      n_checks++; if (m_if.pc !== 32'h24) begin n_fail++; $display("FAIL go_in_run_pc got=%0h exp=24", m_if.pc); end
      m_if.go = 1'b0;
   endtask

   task automatic test_async_reset();
      m_if.en = 1'b1; m_if.jump = 1'b1; m_if.jmp_target = 32'h40;
      tick();
      m_if.jump = 1'b0; m_if.halt_req = 1'b1;
      tick();
      n_checks++; if (m_if.halted !== 1'b1) begin n_fail++; $display("FAIL arst_pre_halted got=%0b exp=1", m_if.halted); end
      n_checks++; if (m_if.pc !== 32'h40) begin n_fail++; $display("FAIL arst_pre_pc got=%0h exp=40", m_if.pc); end
      m_if.halt_req = 1'b0; m_if.en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (m_if.pc !== 32'h0) begin n_fail++; $display("FAIL arst_pc got=%0h exp=0", m_if.pc); end
      n_checks++; if (m_if.halted !== 1'b0) begin n_fail++; $display("FAIL arst_halted got=%0b exp=0", m_if.halted); end
      n_checks++; if (m_if.redirect !== 1'b0) begin n_fail++; $display("FAIL arst_redirect got=%0b exp=0", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'h0) begin n_fail++; $display("FAIL arst_adv_cnt got=%0d exp=0", m_if.adv_cnt); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_trap();
      logic [31:0] exp_pc1;
      logic [31:0] exp_pc2;
      logic        exp_trap;
`ifdef PC_ALIGN_CHK_EN
      exp_pc1 = 32'h80;  exp_pc2 = 32'h84;  exp_trap = 1'b1;
`else
      exp_pc1 = 32'h102; exp_pc2 = 32'h106; exp_trap = 1'b0;
`endif
      m_if.en = 1'b1; m_if.jump = 1'b1; m_if.jmp_target = 32'h102;
      tick();
      n_checks++; if (m_if.pc !== exp_pc1) begin n_fail++; $display("FAIL trap_pc got=%0h exp=%0h", m_if.pc, exp_pc1); end
      n_checks++; if (m_if.trap !== exp_trap) begin n_fail++; $display("FAIL trap_flag got=%0b exp=%0b", m_if.trap, exp_trap); end
      n_checks++; if (m_if.redirect !== 1'b1) begin n_fail++; $display("FAIL trap_redirect got=%0b exp=1", m_if.redirect); end
      n_checks++; if (m_if.adv_cnt !== 32'd1) begin n_fail++; $display("FAIL trap_adv_cnt got=%0d exp=1", m_if.adv_cnt); end
      m_if.jump = 1'b0;
      tick();
      n_checks++; if (m_if.pc !== exp_pc2) begin n_fail++; $display("FAIL trap_next_pc got=%0h exp=%0h", m_if.pc, exp_pc2); end
      n_checks++; if (m_if.trap !== 1'b0) begin n_fail++; $display("FAIL trap_clear got=%0b exp=0", m_if.trap); end
      m_if.en = 1'b0;
   endtask

   task automatic test_wrap_saturate();
      logic [7:0] exp_pc [4];
      exp_pc[0] = 8'h00; exp_pc[1] = 8'h04; exp_pc[2] = 8'h08; exp_pc[3] = 8'h0C;
      apply_reset();
      s_if.en = 1'b1; s_if.jump = 1'b1; s_if.jmp_target = 8'hFC;
      tick();
      n_checks++; if (s_if.pc !== 8'hFC) begin n_fail++; $display("FAIL wrap_setup_pc got=%0h exp=fc", s_if.pc); end
      n_checks++; if (s_if.pc_plus !== 8'h00) begin n_fail++; $display("FAIL wrap_pc_plus got=%0h exp=0", s_if.pc_plus); end
      s_if.jump = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (s_if.pc !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_seq_pc step=%0d got=%0h exp=%0h", i, s_if.pc, exp_pc[i]); end
      end
      n_checks++; if (s_if.adv_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_adv_cnt got=%0d exp=3", s_if.adv_cnt); end
      s_if.branch = 1'b1; s_if.br_offset = 8'hF0;
      tick();
      n_checks++; if (s_if.pc !== 8'h00) begin n_fail++; $display("FAIL wrap_branch_pc got=%0h exp=0", s_if.pc); end
      n_checks++; if (s_if.adv_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold_adv_cnt got=%0d exp=3", s_if.adv_cnt); end
      n_checks++; if (s_if.redirect !== 1'b1) begin n_fail++; $display("FAIL wrap_branch_redirect got=%0b exp=1", s_if.redirect); end
      s_if.branch = 1'b0; s_if.en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_sequential();
      test_stall_jump_branch();
      test_priority();
      test_async_reset();
      test_trap();
      test_wrap_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
